// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART level-frame receive controller.
// The frame checksum is only used when FRAME_CHECKSUM_EN is defined.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        CHAN  = 2'd1,
        LEVEL = 2'd2,
        CSUM  = 2'd3
    } frame_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Checksum byte that must follow the level byte in a 4-byte frame.
    function automatic logic [7:0] frame_csum(input logic [7:0] ch, input logic [7:0] lvl);
        return ch ^ lvl ^ SYNC_BYTE;
    endfunction

endpackage

// File: rtl/uart_frame_ctrl_timer.sv
// Inter-byte timeout counter for the frame controller.
// Counts while run is high, clears on clr or when idle, and pulses
// expired in the TIMEOUT-th counting cycle unless clr is present.
module frame_timer #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    assign expired = run & ~clr & (cnt == LAST);

    // Count cycles spent waiting for the next byte; restart on any byte or expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || !run || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_frame_ctrl.sv
// Byte-level level-frame parser sitting behind the UART receiver.
// Frames: SYNC (0xA5), channel, level, and a checksum byte when the
// FRAME_CHECKSUM_EN macro is defined. Valid frames update one channel's
// level register; malformed or stalled frames bump a saturating error count.
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [8*NUM_CH-1:0]   levels,
    output logic [NUM_CH-1:0]     update,
    output logic [7:0]            err_cnt,
    output logic                  busy
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [7:0] NUM_CH_B = 8'(NUM_CH);

    frame_state_t    state;
    logic            rx_valid_q;
    logic            byte_stb;
    logic            timer_run;
    logic            expired;
    logic [CH_W-1:0] ch_q;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]      lvl_q;
`endif

    assign byte_stb  = rx_valid & ~rx_valid_q;
    assign timer_run = (state != HUNT);

    frame_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (byte_stb),
        .run     (timer_run),
        .expired (expired)
    );

    // Delay rx_valid so only its rising edge yields a byte; resets high so a
    // level already present when reset lifts is not taken as a new byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b1;
        end else begin
            rx_valid_q <= rx_valid;
        end
    end

    // Frame FSM with registered level, update, error and busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= HUNT;
            ch_q    <= '0;
`ifdef FRAME_CHECKSUM_EN
            lvl_q   <= '0;
`endif
            levels  <= '0;
            update  <= '0;
            err_cnt <= '0;
            busy    <= 1'b0;
        end else begin
            update <= '0;
            if (byte_stb) begin
                case (state)
                    HUNT: begin
                        if (rx_data == SYNC_BYTE) begin
                            state <= CHAN;
                            busy  <= 1'b1;
                        end
                    end
                    CHAN: begin
                        if (rx_data < NUM_CH_B) begin
                            ch_q  <= rx_data[CH_W-1:0];
                            state <= LEVEL;
                        end else begin
                            err_cnt <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
                            state   <= HUNT;
                            busy    <= 1'b0;
                        end
                    end
                    LEVEL: begin
`ifdef FRAME_CHECKSUM_EN
                        lvl_q <= rx_data;
                        state <= CSUM;
`else
                        levels[{ch_q, 3'b000} +: 8] <= rx_data;
                        update <= NUM_CH'(1) << ch_q;
                        state  <= HUNT;
                        busy   <= 1'b0;
`endif
                    end
`ifdef FRAME_CHECKSUM_EN
                    CSUM: begin
                        if (rx_data == frame_csum(8'(ch_q), lvl_q)) begin
                            levels[{ch_q, 3'b000} +: 8] <= lvl_q;
                            update <= NUM_CH'(1) << ch_q;
                        end else begin
                            err_cnt <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
                        end
                        state <= HUNT;
                        busy  <= 1'b0;
                    end
`endif
                    default: begin
                        state <= HUNT;
                        busy  <= 1'b0;
                    end
                endcase
            end else if (expired) begin
                err_cnt <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
                state   <= HUNT;
                busy    <= 1'b0;
            end
        end
    end

endmodule
